serial_subtractor_controller: RTL and testbench

Bit-serial N-bit subtract engine built around one full_subtractor_structure instance, port order (BIN, A, B, BOUT, SUB).
- Latches two WIDTH-bit unsigned operands on a START handshake.
- Feeds the operands LSB-first through the 1-bit subtractor, one bit per clock, with the borrow registered between cycles.
- Reports the WIDTH-bit difference and the final borrow with a one-cycle DONE strobe.
- Lets the team reuse the 1-bit cell as a multi-bit subtractor for a minimal gate count.

---
 rtl/serial_subtractor_controller.sv | 121 ++++++++++++
 tb/tb_serial_subtractor_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor_controller.sv
// rtl/serial_subtractor_controller.sv - bit-serial WIDTH-bit subtractor around one 1-bit full-subtractor cell
// Optional initial borrow input enabled by defining BORROW_IN_EN.

module full_subtractor_structure (
  input  logic bin,
  input  logic a,
  input  logic b,
  output logic bout,
  output logic sub
);

  logic axb;

  assign axb  = a ^ b;
  assign sub  = axb ^ bin;
  assign bout = (~a & b) | (~axb & bin);

endmodule

module serial_subtractor_controller #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef BORROW_IN_EN
  input  logic             bin,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             borrow_q;
  logic [CW-1:0]    cnt;
  logic             bin_init;
  logic             fs_bout;
  logic             fs_sub;

`ifdef BORROW_IN_EN
  assign bin_init = bin;
`else
  assign bin_init = 1'b0;
`endif

  full_subtractor_structure u_cell (
    .bin  (borrow_q),
    .a    (sa[0]),
    .b    (sb[0]),
    .bout (fs_bout),
    .sub  (fs_sub)
  );

  // Result bits enter at the MSB so after WIDTH shifts the LSB-first stream lands in order.
  generate
    if (WIDTH == 1) begin : g_sr1
      assign sr_next = fs_sub;
    end else begin : g_srn
      assign sr_next = {fs_sub, sr[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      sa       <= '0;
      sb       <= '0;
      sr       <= '0;
      borrow_q <= 1'b0;
      cnt      <= '0;
      diff     <= '0;
      bout     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sa       <= a;
            sb       <= b;
            sr       <= '0;
            borrow_q <= bin_init;
            cnt      <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          sa       <= sa >> 1;
          sb       <= sb >> 1;
          sr       <= sr_next;
          borrow_q <= fs_bout;
          cnt      <= cnt + CW'(1);
          if (cnt == LAST) begin
            diff  <= sr_next;
            bout  <= fs_bout;
            state <= S_FINISH;
          end
        end
        S_FINISH: state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_FINISH);

endmodule

// File: tb/tb_serial_subtractor_controller.sv
// tb/tb_serial_subtractor_controller.sv - directed and random checks of the serial subtractor against an arithmetic model

module tb_serial_subtractor_controller;

  localparam int W = 4;
  localparam int MASK = (1 << W) - 1;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] last_diff;
  logic         last_bout;

  serial_subtractor_controller #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
`ifdef BORROW_IN_EN
    .bin   (bin),
`endif
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_diff(input int x, input int y, input int c);
    return W'((x - y - c) & MASK);
  endfunction

  function automatic logic model_bout(input int x, input int y, input int c);
    return (x < y + c);
  endfunction

  // Presents operands on a falling edge and returns just after the accepting rising edge.
  task automatic accept(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv, input logic hold);
    @(negedge clk);
    a = av; b = bv; bin = cv; start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  // Follows one operation from the cycle after accept through its DONE cycle.
  task automatic expect_op(input string tag, input logic [W-1:0] ed, input logic eb);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      chk({tag, "_busy"}, busy, 1);
      chk({tag, "_nodone"}, done, 0);
      chk({tag, "_diffhold"}, diff, last_diff);
      chk({tag, "_bouthold"}, bout, last_bout);
    end
    @(negedge clk);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_busy_fin"}, busy, 0);
    chk({tag, "_diff"}, diff, ed);
    chk({tag, "_bout"}, bout, eb);
    last_diff = ed;
    last_bout = eb;
  endtask

  task automatic op(input string tag, input int av, input int bv, input int cv);
    accept(W'(av), W'(bv), cv[0], 1'b0);
    expect_op(tag, model_diff(av, bv, cv), model_bout(av, bv, cv));
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; bin = 1'b0;
    last_diff = '0; last_bout = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_diff", diff, 0);
    chk("rst_bout", bout, 0);
    rst_n = 1'b1;

    op("t1_5m3", 5, 3, 0);
    chk("t1_diff_lit", diff, 4'b0010);
    @(negedge clk);
    chk("t1_done_once", done, 0);

    op("t2_3m5", 3, 5, 0);
    chk("t2_diff_lit", diff, 14);
    op("t2_0m1", 0, 1, 0);
    chk("t2_diff_lit2", diff, 15);

    // back-to-back with START held high
    accept(W'(15), W'(15), 1'b0, 1'b1);
    expect_op("t3_a", 0, 0);
    a = '0; b = '0;
    @(negedge clk);
    chk("t3_gap_busy", busy, 0);
    chk("t3_gap_done", done, 0);
    expect_op("t3_b", 0, 0);
    start = 1'b0;

    // START and operand noise during RUN/FINISH
    accept(W'(9), W'(4), 1'b0, 1'b0);
    for (int i = 0; i < W; i++) begin
      start = 1'b1;
      a = (i % 2 == 0) ? W'(1) : W'($urandom);
      b = (i % 2 == 0) ? W'(7) : W'($urandom);
      @(negedge clk);
      chk("t4_busy", busy, 1);
    end
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_diff", diff, 5);
    chk("t4_bout", bout, 0);
    last_diff = W'(5); last_bout = 1'b0;
    start = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      @(negedge clk);
      chk("t4_no_second_done", done, 0);
      chk("t4_no_second_busy", busy, 0);
    end

    // asynchronous reset mid-RUN
    accept(W'(12), W'(3), 1'b0, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_diff", diff, 0);
    chk("t5_bout", bout, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_diff = '0; last_bout = 1'b0;
    for (int i = 0; i < W + 3; i++) begin
      @(negedge clk);
      chk("t5_idle_done", done, 0);
      chk("t5_idle_busy", busy, 0);
    end

`ifdef BORROW_IN_EN
    op("t6_8m0b1", 8, 0, 1);
    chk("t6_lit1", diff, 7);
    op("t6_0m0b1", 0, 0, 1);
    chk("t6_lit2", diff, 15);
    chk("t6_lit2b", bout, 1);
`else
    op("t6_8m0", 8, 0, 0);
    chk("t6_lit1", diff, 8);
    op("t6_0m0", 0, 0, 0);
    chk("t6_lit2", diff, 0);
    chk("t6_lit2b", bout, 0);
`endif

    for (int n = 0; n < 25; n++) begin
      int ra, rb, rc;
      ra = int'($urandom_range(MASK, 0));
      rb = int'($urandom_range(MASK, 0));
`ifdef BORROW_IN_EN
      rc = int'($urandom_range(1, 0));
`else
      rc = 0;
`endif
      op("rnd", ra, rb, rc);
      if ($urandom_range(1, 0) == 1) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
